tnoc_flit_transmitter: RTL and testbench

TNOC_FLIT_TRANSMITTER -- requirements
Module: tnoc_flit_transmitter

---
 rtl/tnoc_flit_transmitter.sv | 152 +++++++++++++++
 tb/tb_tnoc_flit_transmitter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_flit_transmitter.sv
// Local-port packet injector: turns one request plus its payload beats into a
// header flit followed by payload flits on a single virtual channel.
module tnoc_flit_transmitter #(
    parameter int  ID_X_WIDTH = 3,
    parameter int  ID_Y_WIDTH = 3,
    parameter int  CHANNELS   = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_LENGTH = 16,
    localparam int VC_WIDTH   = $clog2(CHANNELS),
    localparam int LEN_WIDTH  = $clog2(MAX_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_X_WIDTH-1:0] i_id_x,
    input  logic [ID_Y_WIDTH-1:0] i_id_y,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ID_X_WIDTH-1:0] i_req_dest_x,
    input  logic [ID_Y_WIDTH-1:0] i_req_dest_y,
    input  logic [VC_WIDTH-1:0]   i_req_vc,
    input  logic [LEN_WIDTH-1:0]  i_req_length,
    input  logic                  i_payload_valid,
    output logic                  o_payload_ready,
    input  logic [DATA_WIDTH-1:0] i_payload_data,
    output logic [CHANNELS-1:0]   o_flit_valid,
    input  logic [CHANNELS-1:0]   i_flit_ready,
    output logic                  o_flit_head,
    output logic                  o_flit_tail,
    output logic [DATA_WIDTH-1:0] o_flit_data,
    output logic                  o_busy,
    output logic [1:0]            o_dbg_state
);

    // Handshakes (request, payload, flit): a transfer happens on a rising edge
    // where valid and ready are both high; a raised valid stays put until then.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_LENGTH);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [VC_WIDTH-1:0]   r_vc;
    logic [LEN_WIDTH-1:0]  r_length;
    logic [LEN_WIDTH-1:0]  r_loaded;
    logic [LEN_WIDTH-1:0]  r_accepted;
    logic                  r_flit_valid;
    logic                  r_flit_head;
    logic                  r_flit_tail;
    logic [DATA_WIDTH-1:0] r_flit_data;

    logic [LEN_WIDTH-1:0]  w_req_length;
    logic [DATA_WIDTH-1:0] w_header;
    logic                  w_flit_ready;
    logic                  w_accept;
    logic                  w_req_hs;
    logic                  w_pay_hs;
    logic                  w_payload_ready;

    assign w_req_length = (i_req_length > MAX_LEN) ? MAX_LEN : i_req_length;
    assign w_header     = DATA_WIDTH'({i_req_dest_x, i_req_dest_y, i_id_x, i_id_y, w_req_length});

    // Only the captured VC's ready matters; the other lanes are ignored.
    assign w_flit_ready = i_flit_ready[r_vc];
    assign w_accept     = r_flit_valid & w_flit_ready;
    assign o_req_ready  = (r_state == IDLE) & ~rst;
    assign w_req_hs     = i_req_valid & o_req_ready;
    assign w_pay_hs     = i_payload_valid & w_payload_ready;

    always_comb begin
        w_payload_ready = 1'b0;
        case (r_state)
            HEADER:  w_payload_ready = (r_length != '0) & w_accept;
            PAYLOAD: w_payload_ready = (r_loaded < r_length) & (~r_flit_valid | w_flit_ready);
            default: w_payload_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_hs) w_next_state = HEADER;
            end
            HEADER: begin
                if (w_accept) w_next_state = (r_length == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                if (w_accept && (r_accepted == (r_length - ONE))) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vc         <= '0;
            r_length     <= '0;
            r_loaded     <= '0;
            r_accepted   <= '0;
            r_flit_valid <= 1'b0;
            r_flit_head  <= 1'b0;
            r_flit_tail  <= 1'b0;
            r_flit_data  <= '0;
        end else begin
            if (w_req_hs) begin
                r_vc         <= i_req_vc;
                r_length     <= w_req_length;
                r_flit_valid <= 1'b1;
                r_flit_head  <= 1'b1;
                r_flit_tail  <= (w_req_length == '0);
                r_flit_data  <= w_header;
            end else if (w_pay_hs) begin
                r_flit_valid <= 1'b1;
                r_flit_head  <= 1'b0;
                r_flit_tail  <= ((r_loaded + ONE) == r_length);
                r_flit_data  <= i_payload_data;
                r_loaded     <= r_loaded + ONE;
            end else if (w_accept) begin
                r_flit_valid <= 1'b0;
            end
            if ((r_state == PAYLOAD) && w_accept) r_accepted <= r_accepted + ONE;
            // Counters restart from zero for every packet.
            if ((r_state != IDLE) && (w_next_state == IDLE)) begin
                r_loaded   <= '0;
                r_accepted <= '0;
            end
        end
    end

    always_comb begin
        o_flit_valid       = '0;
        o_flit_valid[r_vc] = r_flit_valid;
    end

    assign o_payload_ready = w_payload_ready;
    assign o_flit_head     = r_flit_head;
    assign o_flit_tail     = r_flit_tail;
    assign o_flit_data     = r_flit_data;
    assign o_busy          = (r_state != IDLE);
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_tnoc_flit_transmitter.sv
// Randomized bench for tnoc_flit_transmitter: a packet-level model predicts the
// flit stream and handshake readiness each cycle; directed cases cover corners.
module tb_tnoc_flit_transmitter;

    localparam int XW   = 3;
    localparam int YW   = 3;
    localparam int CH   = 2;
    localparam int DW   = 32;
    localparam int MAXL = 16;
    localparam int VW   = $clog2(CH);
    localparam int LW   = $clog2(MAXL + 1);
    localparam int FW   = DW + 2;
    localparam int ID_X = 1;
    localparam int ID_Y = 2;

    typedef logic [FW-1:0] flit_t;
    typedef struct { int dx; int dy; int vc; int len; } req_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [XW-1:0] i_id_x = XW'(ID_X);
    logic [YW-1:0] i_id_y = YW'(ID_Y);
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [XW-1:0] i_req_dest_x = '0;
    logic [YW-1:0] i_req_dest_y = '0;
    logic [VW-1:0] i_req_vc = '0;
    logic [LW-1:0] i_req_length = '0;
    logic          i_payload_valid = 1'b0;
    logic          o_payload_ready;
    logic [DW-1:0] i_payload_data = '0;
    logic [CH-1:0] o_flit_valid;
    logic [CH-1:0] i_flit_ready = '0;
    logic          o_flit_head;
    logic          o_flit_tail;
    logic [DW-1:0] o_flit_data;
    logic          o_busy;
    logic [1:0]    o_dbg_state;

    tnoc_flit_transmitter #(
        .ID_X_WIDTH(XW), .ID_Y_WIDTH(YW), .CHANNELS(CH),
        .DATA_WIDTH(DW), .MAX_LENGTH(MAXL)
    ) dut (
        .clk(clk), .rst(rst), .i_id_x(i_id_x), .i_id_y(i_id_y),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_dest_x(i_req_dest_x), .i_req_dest_y(i_req_dest_y),
        .i_req_vc(i_req_vc), .i_req_length(i_req_length),
        .i_payload_valid(i_payload_valid), .o_payload_ready(o_payload_ready),
        .i_payload_data(i_payload_data),
        .o_flit_valid(o_flit_valid), .i_flit_ready(i_flit_ready),
        .o_flit_head(o_flit_head), .o_flit_tail(o_flit_tail),
        .o_flit_data(o_flit_data), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    int      n_checks = 0;
    int      n_errors = 0;
    flit_t   exp_q[$];
    req_t    req_q[$];
    logic [DW-1:0] pay_q[$];
    bit      m_active = 0;
    int      m_len = 0, m_vc = 0, m_sent = 0, m_loaded = 0;
    logic [DW-1:0] m_last_data = '0;
    bit      req_hold = 0, pay_hold = 0;
    int      p_req = 100, p_pay = 100, p_rdy = 100;
    int      stall_len[32];
    int      cyc = 0;
    int      first_acc_cyc = 0, last_acc_cyc = 0;
    int      n_head_acc = 0, n_tail_acc = 0, n_pay_acc = 0;
    logic [DW-1:0] hdr_obs = '0;
    bit      v0_seen = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Header layout from LSB: length, src_y, src_x, dest_y, dest_x.
    function automatic logic [DW-1:0] hdr_data(int dx, int dy, int sx, int sy, int len);
        longint v;
        v = longint'(len)
          + (longint'(sy) << LW)
          + (longint'(sx) << (LW + YW))
          + (longint'(dy) << (LW + YW + XW))
          + (longint'(dx) << (LW + 2 * YW + XW));
        return DW'(v);
    endfunction

    task automatic reset_stats();
        n_head_acc = 0; n_tail_acc = 0; n_pay_acc = 0;
        v0_seen = 0; hdr_obs = '0;
        for (int i = 0; i < 32; i++) stall_len[i] = 0;
    endtask

    task automatic add_pkt(input int dx, input int dy, input int vc, input int len,
                           input logic [DW-1:0] base, input bit rnd);
        req_t r;
        int   ls;
        r.dx = dx; r.dy = dy; r.vc = vc; r.len = len;
        req_q.push_back(r);
        ls = (len > MAXL) ? MAXL : len;
        for (int i = 0; i < ls; i++) pay_q.push_back(rnd ? DW'($urandom) : base + DW'(i));
    endtask

    // ---------------- driver + per-cycle comparison ----------------
    task automatic step();
        bit ev_on, rdy_t, acc, exp_pay, exp_req, pay_hs, req_hs;
        logic [CH-1:0] ev;
        req_t  r;
        flit_t f;
        int    ls;
        @(posedge clk);
        #1;
        cyc++;
        ev_on = m_active && (m_loaded + 1 > m_sent);
        if (req_hold || (req_q.size() > 0 && $urandom_range(99) < p_req)) begin
            r = req_q[0];
            i_req_valid  = 1'b1;
            i_req_dest_x = XW'(r.dx);
            i_req_dest_y = YW'(r.dy);
            i_req_vc     = VW'(r.vc);
            i_req_length = LW'(r.len);
        end else begin
            i_req_valid  = 1'b0;
            i_req_dest_x = XW'($urandom);
            i_req_dest_y = YW'($urandom);
            i_req_vc     = VW'($urandom);
            i_req_length = LW'($urandom);
        end
        if (pay_hold || (pay_q.size() > 0 && $urandom_range(99) < p_pay)) begin
            i_payload_valid = 1'b1;
            i_payload_data  = pay_q[0];
        end else begin
            i_payload_valid = 1'b0;
            i_payload_data  = DW'($urandom);
        end
        if (ev_on && stall_len[m_sent] > 0) begin
            rdy_t = 1'b0;
            stall_len[m_sent]--;
        end else begin
            rdy_t = ($urandom_range(99) < p_rdy);
        end
        for (int c = 0; c < CH; c++) i_flit_ready[c] = (c == m_vc) ? rdy_t : 1'b1;
        #1;
        acc     = ev_on && rdy_t;
        exp_req = !m_active;
        exp_pay = m_active && (m_loaded < m_len) && (m_sent >= 1 || acc) && (!ev_on || rdy_t);
        ev = '0;
        if (ev_on) ev[m_vc] = 1'b1;
        check_val("flit_valid", o_flit_valid, ev);
        check_val("req_ready", o_req_ready, exp_req);
        check_val("payload_ready", o_payload_ready, exp_pay);
        check_val("busy", o_busy, m_active);
        if (o_flit_valid[0]) v0_seen = 1;
        if (ev_on) check_val("flit", {o_flit_head, o_flit_tail, o_flit_data},
                             (exp_q.size() > 0) ? exp_q[0] : 'x);
        else       check_val("hold_data", o_flit_data, m_last_data);

        pay_hs = i_payload_valid && exp_pay;
        req_hs = i_req_valid && exp_req;
        if (acc) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (o_flit_head) begin
                n_head_acc++;
                first_acc_cyc = cyc;
                hdr_obs = o_flit_data;
            end else begin
                n_pay_acc++;
            end
            if (o_flit_tail) begin
                n_tail_acc++;
                last_acc_cyc = cyc;
            end
            m_sent++;
            if (m_sent == m_len + 1) m_active = 0;
        end
        if (pay_hs) begin
            m_loaded++;
            exp_q.push_back({1'b0, (m_loaded == m_len), i_payload_data});
            m_last_data = i_payload_data;
            void'(pay_q.pop_front());
            pay_hold = 0;
        end else begin
            pay_hold = i_payload_valid;
        end
        if (req_hs) begin
            r  = req_q.pop_front();
            ls = (r.len > MAXL) ? MAXL : r.len;
            m_active = 1; m_len = ls; m_vc = r.vc; m_sent = 0; m_loaded = 0;
            f = {1'b1, (ls == 0), hdr_data(r.dx, r.dy, ID_X, ID_Y, ls)};
            exp_q.push_back(f);
            m_last_data = f[DW-1:0];
            req_hold = 0;
        end else begin
            req_hold = i_req_valid;
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((req_q.size() > 0 || pay_q.size() > 0 || m_active) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, (n < budget), 1);
    endtask

    task automatic chk_reset(input string tag);
        check_val({tag, "_valid"}, o_flit_valid, 0);
        check_val({tag, "_head"}, o_flit_head, 0);
        check_val({tag, "_tail"}, o_flit_tail, 0);
        check_val({tag, "_data"}, o_flit_data, 0);
        check_val({tag, "_req_ready"}, o_req_ready, 0);
        check_val({tag, "_payload_ready"}, o_payload_ready, 0);
        check_val({tag, "_busy"}, o_busy, 0);
    endtask

    // Reset lands between edges so the async path is exercised; requests are
    // offered throughout reset and must not be taken.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_length = LW'(3);
        i_payload_valid = 1'b1; i_flit_ready = '1;
        #1;
        chk_reset({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        chk_reset({tag, "_held"});
        rst = 1'b0;
        i_req_valid = 1'b0; i_payload_valid = 1'b0;
        exp_q.delete(); req_q.delete(); pay_q.delete();
        m_active = 0; m_len = 0; m_sent = 0; m_loaded = 0;
        m_last_data = '0; req_hold = 0; pay_hold = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        reset_stats();
        apply_reset("rst0");

        // single header-only packet on VC1
        reset_stats();
        p_req = 100; p_pay = 100; p_rdy = 100;
        add_pkt(3, 0, 1, 0, '0, 0);
        drain(50, "t1_drain");
        check_val("t1_hdr_data", hdr_obs, 32'h0000_C140);
        check_val("t1_vc0_never", v0_seen, 0);
        check_val("t1_tails", n_tail_acc, 1);

        // four-beat packet, continuous
        reset_stats();
        add_pkt(5, 6, 0, 4, 32'hA0, 0);
        drain(50, "t2_drain");
        check_val("t2_span", last_acc_cyc - first_acc_cyc, 4);
        check_val("t2_payloads", n_pay_acc, 4);

        // stalls on header and on the second payload flit
        reset_stats();
        stall_len[0] = 5; stall_len[2] = 5;
        add_pkt(2, 7, 0, 3, 32'hB0, 0);
        drain(60, "t3_drain");
        check_val("t3_span", last_acc_cyc - first_acc_cyc, 8);
        check_val("t3_payloads", n_pay_acc, 3);

        // oversize length saturates
        reset_stats();
        add_pkt(7, 7, 1, 20, 32'h100, 0);
        drain(80, "t4_drain");
        check_val("t4_hdr_len", hdr_obs[LW-1:0], MAXL);
        check_val("t4_payloads", n_pay_acc, MAXL);
        check_val("t4_tails", n_tail_acc, 1);

        // reset after the second of four payload flits
        reset_stats();
        add_pkt(4, 4, 1, 4, 32'hC0, 0);
        n = 0;
        while (!(m_active && m_sent >= 3) && n < 50) begin
            step();
            n++;
        end
        check_val("t5_reach", (n < 50), 1);
        apply_reset("t5");
        reset_stats();
        add_pkt(0, 3, 1, 1, 32'hD0, 0);
        drain(50, "t5_drain");
        check_val("t5_heads", n_head_acc, 1);
        check_val("t5_tails", n_tail_acc, 1);

        // random traffic
        reset_stats();
        p_req = 60; p_pay = 70; p_rdy = 50;
        for (int i = 0; i < 100; i++)
            add_pkt($urandom_range(7), $urandom_range(7), $urandom_range(CH - 1),
                    $urandom_range(22), '0, 1);
        drain(20000, "t6_drain");
        check_val("t6_heads", n_head_acc, 100);
        check_val("t6_tails", n_tail_acc, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
